// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over raster-order pixels.
// Only the even-row horizontal pair maxima are kept, in a half-line buffer.
`timescale 1ns/1ps
module maxpool2x2_stream #(
    parameter int DW     = 8,
    parameter int IMG_W  = 30,
    parameter int IMG_H  = 30,
    parameter int CW     = 5,
    parameter int RW     = 5,
    parameter int SIGNED = 0
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iVALID,
    input  logic [DW-1:0] iDATA,
    output logic          oVALID,
    output logic [DW-1:0] oDATA,
    output logic          oEOF
);

    localparam int HW = IMG_W / 2;
    localparam int IW = (CW > 1) ? CW - 1 : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    generate
        if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2
            || (1 << CW) < IMG_W || (1 << RW) < IMG_H) begin : gBadParam
            $error("maxpool2x2_stream: bad image size or counter width");
        end
    endgenerate

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DW-1:0] hreg;
    logic [DW-1:0] lbuf [HW];
    logic [DW-1:0] hmax;
    logic [DW-1:0] vmax;
    logic [IW-1:0] idx;
    logic          colLast;
    logic          rowLast;
    logic          oddCol;
    logic          oddRow;
    logic          accept;

    function automatic logic [DW-1:0] pmax(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic gt;
        if (SIGNED != 0) gt = $signed(a) > $signed(b);
        else             gt = a > b;
        return gt ? a : b;
    endfunction

    assign colLast = (col == COL_LAST);
    assign rowLast = (row == ROW_LAST);
    assign oddCol  = col[0];
    assign oddRow  = row[0];
    assign idx     = IW'(col >> 1);
    assign accept  = iVALID && !iCLR;
    assign hmax    = pmax(hreg, iDATA);
    assign vmax    = pmax(hmax, lbuf[idx]);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            col    <= '0;
            row    <= '0;
            hreg   <= '0;
            oVALID <= 1'b0;
            oDATA  <= '0;
            oEOF   <= 1'b0;
        end else if (iCLR) begin
            col    <= '0;
            row    <= '0;
            hreg   <= '0;
            oVALID <= 1'b0;
            oEOF   <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            oEOF   <= 1'b0;
            if (iVALID) begin
                if (!oddCol) hreg <= iDATA;
                if (oddCol && oddRow) begin
                    oVALID <= 1'b1;
                    oDATA  <= vmax;
                    oEOF   <= rowLast && colLast;
                end
                if (colLast) begin
                    col <= '0;
                    row <= rowLast ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Line buffer holds data only; its contents need no reset.
    always_ff @(posedge iCLK) begin
        if (accept && oddCol && !oddRow) lbuf[idx] <= hmax;
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: 4x2 unsigned/signed and 30x30 instances,
// scoreboard queue of expected strobes checked by a negedge monitor.
`timescale 1ns/1ps
module tb_maxpool2x2_stream;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       clr   = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;

    int sel     = 0;
    int cyc     = 0;
    int errors  = 0;
    int checks  = 0;
    int nStrobe = 0;

    typedef struct {
        logic [7:0] v;
        logic       e;
        int         c;
    } exp_t;
    exp_t q[$];

    logic       vA, vS, vB;
    logic       oVA, oVS, oVB;
    logic       oEA, oES, oEB;
    logic [7:0] oDA, oDS, oDB;

    assign vA = valid && (sel == 0);
    assign vS = valid && (sel == 1);
    assign vB = valid && (sel == 2);

    maxpool2x2_stream #(.DW(8), .IMG_W(4), .IMG_H(2), .CW(2), .RW(1), .SIGNED(0)) uA (
        .iCLK(clk), .iRSTn(rstn), .iCLR(clr), .iVALID(vA), .iDATA(data),
        .oVALID(oVA), .oDATA(oDA), .oEOF(oEA));

    maxpool2x2_stream #(.DW(8), .IMG_W(4), .IMG_H(2), .CW(2), .RW(1), .SIGNED(1)) uS (
        .iCLK(clk), .iRSTn(rstn), .iCLR(clr), .iVALID(vS), .iDATA(data),
        .oVALID(oVS), .oDATA(oDS), .oEOF(oES));

    maxpool2x2_stream uB (
        .iCLK(clk), .iRSTn(rstn), .iCLR(clr), .iVALID(vB), .iDATA(data),
        .oVALID(oVB), .oDATA(oDB), .oEOF(oEB));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic       mV, mE;
    logic [7:0] mD;
    exp_t       mX;

    always @(negedge clk) begin
        if (rstn) begin
            case (sel)
                0:       begin mV = oVA; mE = oEA; mD = oDA; end
                1:       begin mV = oVS; mE = oES; mD = oDS; end
                default: begin mV = oVB; mE = oEB; mD = oDB; end
            endcase
            if (mV) begin
                nStrobe++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_strobe: got data=%0h eof=%0b, required no strobe", mD, mE);
                end else begin
                    mX = q.pop_front();
                    if (mD !== mX.v || mE !== mX.e || cyc != mX.c) begin
                        errors++;
                        $display("FAIL strobe: got data=%0h eof=%0b cyc=%0d, required data=%0h eof=%0b cyc=%0d",
                                 mD, mE, cyc, mX.v, mX.e, mX.c);
                    end
                end
            end else if (mE !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL eof_no_valid: got eof=%0b, required 0", mE);
            end
        end
    end

    task automatic send(input logic [7:0] d, input int gap, input bit push,
                        input logic [7:0] ev, input bit ee);
        exp_t t;
        repeat (gap) begin
            valid = 1'b0;
            @(posedge clk); #1;
        end
        valid = 1'b1;
        data  = d;
        if (push) begin
            t.v = ev;
            t.e = ee;
            t.c = cyc + 1;
            q.push_back(t);
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic frame4(input logic [7:0] p [8], input logic [7:0] e0,
                          input logic [7:0] e1, input int maxGap);
        int gap;
        for (int i = 0; i < 8; i++) begin
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            send(p[i], gap, (i == 5) || (i == 7), (i == 5) ? e0 : e1, i == 7);
        end
    endtask

    task automatic drain(input string name, input int want);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d pending, required 0", name, q.size());
        end
        q.delete();
        checks++;
        if (nStrobe != want) begin
            errors++;
            $display("FAIL %s_count: got %0d strobes, required %0d", name, nStrobe, want);
        end
        nStrobe = 0;
    endtask

    logic [7:0] basic [8];
    logic [7:0] sgn   [8];

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++;
        if ({oVA, oEA, oDA} !== 9'h0) begin
            errors++;
            $display("FAIL reset_A: got v=%0b e=%0b d=%0h, required 0", oVA, oEA, oDA);
        end
        checks++;
        if ({oVS, oES, oDS} !== 9'h0) begin
            errors++;
            $display("FAIL reset_S: got v=%0b e=%0b d=%0h, required 0", oVS, oES, oDS);
        end
        checks++;
        if ({oVB, oEB, oDB} !== 9'h0) begin
            errors++;
            $display("FAIL reset_B: got v=%0b e=%0b d=%0h, required 0", oVB, oEB, oDB);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        sel = 0;
        nStrobe = 0;
        frame4(basic, 8'd9, 8'd8, 0);
        drain("basic", 2);
    endtask

    task automatic test_sign();
        sel = 1;
        nStrobe = 0;
        frame4(sgn, 8'h02, 8'h7F, 0);
        drain("signed", 2);
        sel = 0;
        frame4(sgn, 8'hFD, 8'h90, 0);
        drain("unsigned", 2);
    endtask

    task automatic test_bubbles();
        sel = 0;
        nStrobe = 0;
        frame4(basic, 8'd9, 8'd8, 5);
        drain("bubbles", 2);
    endtask

    function automatic logic [7:0] ramp(input int r, input int c);
        return 8'((r * 30 + c) % 256);
    endfunction

    task automatic test_frame_wrap();
        logic [7:0] m;
        logic [7:0] w [4];
        sel = 2;
        nStrobe = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 30; r++) begin
                for (int c = 0; c < 30; c++) begin
                    m = 8'h00;
                    if ((r % 2) == 1 && (c % 2) == 1) begin
                        w[0] = ramp(r - 1, c - 1);
                        w[1] = ramp(r - 1, c);
                        w[2] = ramp(r, c - 1);
                        w[3] = ramp(r, c);
                        for (int k = 0; k < 4; k++) if (w[k] > m) m = w[k];
                    end
                    send(ramp(r, c), 0, (r % 2) == 1 && (c % 2) == 1, m,
                         r == 29 && c == 29);
                end
            end
            drain("frame_wrap", 225);
        end
    endtask

    task automatic test_clr();
        sel = 0;
        nStrobe = 0;
        for (int i = 0; i < 4; i++) send(basic[i], 0, 1'b0, 8'h00, 1'b0);
        clr = 1'b1;
        send(basic[4], 0, 1'b0, 8'h00, 1'b0);
        clr = 1'b0;
        checks++;
        if (oDA !== 8'd8 || oVA !== 1'b0) begin
            errors++;
            $display("FAIL clr_hold: got v=%0b d=%0h, required v=0 d=8", oVA, oDA);
        end
        frame4(basic, 8'd9, 8'd8, 0);
        drain("clr", 2);
    endtask

    task automatic test_async_reset();
        sel = 0;
        nStrobe = 0;
        for (int i = 0; i < 6; i++) send(basic[i], 0, 1'b0, 8'h00, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (oVA !== 1'b0) begin
            errors++;
            $display("FAIL arst_valid: got %0b, required 0", oVA);
        end
        checks++;
        if (oEA !== 1'b0) begin
            errors++;
            $display("FAIL arst_eof: got %0b, required 0", oEA);
        end
        checks++;
        if (oDA !== 8'h00) begin
            errors++;
            $display("FAIL arst_data: got %0h, required 0", oDA);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        frame4(basic, 8'd9, 8'd8, 0);
        drain("arst", 2);
    endtask

    initial begin
        basic = '{8'd1, 8'd9, 8'd3, 8'd2, 8'd5, 8'd4, 8'd7, 8'd8};
        sgn   = '{8'hFD, 8'h02, 8'h80, 8'h7F, 8'h01, 8'h00, 8'h81, 8'h90};
        test_reset();
        test_basic();
        test_sign();
        test_bubbles();
        test_frame_wrap();
        test_clr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
